pipe1_sched: RTL and testbench

//  Two-requester round-robin scheduler for the 4-operand, 3-stage arithmetic pipeline F=((A+B)+(C-D))*D.

---
 rtl/pipe1_sched.sv | 177 +++++++++++++++++
 tb/tb_pipe1_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe1_sched.sv
// ---------------------------------------------------------------------------
// pipe1_sched
// Two-requester round-robin scheduler in front of a shared, reset-less
// 3-stage arithmetic pipeline F = ((A+B)+(C-D))*D.  It accepts one operand set
// per clock over valid/ready and drives it into the pipeline. It also carries a
// valid/tag token alongside each set so the result returns to its requester.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   en                issue enable (0 blocks new accepts, in-flight sets drain)
//   v0/v1, rdy0/rdy1  requester valid in / combinational accept out
//   a0..d0, a1..d1    requester operand sets
//   pa..pd            registered operands to the pipeline
//   pf                pipeline result input
//   rv0/rv1, rf       registered one-cycle result pulse per requester + data
//   busy              registered: any token in flight or result pulse pending
//   cnt0/cnt1         wrapping accepted-set counters per requester
// ---------------------------------------------------------------------------
module pipe1_sched #(
    parameter int N   = 10,
    parameter int LAT = 3,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          v0,
    input  logic          v1,
    output logic          rdy0,
    output logic          rdy1,
    input  logic [N-1:0]  a0,
    input  logic [N-1:0]  b0,
    input  logic [N-1:0]  c0,
    input  logic [N-1:0]  d0,
    input  logic [N-1:0]  a1,
    input  logic [N-1:0]  b1,
    input  logic [N-1:0]  c1,
    input  logic [N-1:0]  d1,
    output logic [N-1:0]  pa,
    output logic [N-1:0]  pb,
    output logic [N-1:0]  pc,
    output logic [N-1:0]  pd,
    input  logic [N-1:0]  pf,
    output logic          rv0,
    output logic          rv1,
    output logic [N-1:0]  rf,
    output logic          busy,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    // Operand registers feeding the pipeline
    logic [N-1:0]  pa_q, pa_d, pb_q, pb_d, pc_q, pc_d, pd_q, pd_d;
    // Token shift register: slot k describes the set that entered k+1 edges ago
    logic [LAT:0]  tok_v_q, tok_v_d;
    logic [LAT:0]  tok_t_q, tok_t_d;
    // Result, counters, arbitration pointer, busy flag
    logic          rv0_q, rv0_d, rv1_q, rv1_d;
    logic [N-1:0]  rf_q, rf_d;
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic          prio_q, prio_d;
    logic          busy_q, busy_d;
    logic          rdy0_s, rdy1_s;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    // Round-robin grant: a lone requester always wins, contention goes to prio
    always_comb begin
        rdy0_s = en & v0 & (~prio_q | ~v1);
        rdy1_s = en & v1 & ( prio_q | ~v0);
    end

    // Next-state logic for issue, token tracking and retire
    always_comb begin
        pa_d    = pa_q;
        pb_d    = pb_q;
        pc_d    = pc_q;
        pd_d    = pd_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        prio_d  = prio_q;
        tok_v_d = tok_v_q;
        tok_t_d = tok_t_q;
        rf_d    = rf_q;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;

        // Tokens march in lock-step with the data in the pipeline
        for (int k = 1; k <= LAT; k++) begin
            tok_v_d[k] = tok_v_q[k-1];
            tok_t_d[k] = tok_t_q[k-1];
        end

        if (rdy0_s) begin
            pa_d       = a0;
            pb_d       = b0;
            pc_d       = c0;
            pd_d       = d0;
            tok_v_d[0] = 1'b1;
            tok_t_d[0] = 1'b0;
            cnt0_d     = cnt0_q + CNT_ONE;
            prio_d     = 1'b1;
        end else if (rdy1_s) begin
            pa_d       = a1;
            pb_d       = b1;
            pc_d       = c1;
            pd_d       = d1;
            tok_v_d[0] = 1'b1;
            tok_t_d[0] = 1'b1;
            cnt1_d     = cnt1_q + CNT_ONE;
            prio_d     = 1'b0;
        end else begin
            // Operands hold; the bubble is marked by an invalid token
            tok_v_d[0] = 1'b0;
            tok_t_d[0] = 1'b0;
        end

        // Last slot valid means pf currently carries that token's result
        if (tok_v_q[LAT]) begin
            rf_d  = pf;
            rv0_d = ~tok_t_q[LAT];
            rv1_d =  tok_t_q[LAT];
        end else begin
            rf_d  = rf_q;
        end

        // Registered form of "tokens in flight or result pulse showing"
        busy_d = (|tok_v_d) | rv0_d | rv1_d;
    end

    // State registers; reset drops anything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pa_q    <= {N{1'b0}};
            pb_q    <= {N{1'b0}};
            pc_q    <= {N{1'b0}};
            pd_q    <= {N{1'b0}};
            tok_v_q <= {(LAT+1){1'b0}};
            tok_t_q <= {(LAT+1){1'b0}};
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rf_q    <= {N{1'b0}};
            cnt0_q  <= {CW{1'b0}};
            cnt1_q  <= {CW{1'b0}};
            prio_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            pc_q    <= pc_d;
            pd_q    <= pd_d;
            tok_v_q <= tok_v_d;
            tok_t_q <= tok_t_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            rf_q    <= rf_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            prio_q  <= prio_d;
            busy_q  <= busy_d;
        end
    end

    assign rdy0 = rdy0_s;
    assign rdy1 = rdy1_s;
    assign pa   = pa_q;
    assign pb   = pb_q;
    assign pc   = pc_q;
    assign pd   = pd_q;
    assign rv0  = rv0_q;
    assign rv1  = rv1_q;
    assign rf   = rf_q;
    assign busy = busy_q;
    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;

endmodule

// File: tb/tb_pipe1_sched.sv
// ---------------------------------------------------------------------------
// tb_pipe1_sched
// Self-checking bench for pipe1_sched with a behavioural 3-stage pipeline
// F=((A+B)+(C-D))*D wired to pa..pd/pf.  Expected results are queued when an
// accept is predicted and compared when a result pulse appears.
// ---------------------------------------------------------------------------
module tb_pipe1_sched;

    localparam int N  = 10;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          en, v0, v1;
    logic          rdy0, rdy1;
    logic [N-1:0]  a0, b0, c0, d0, a1, b1, c1, d1;
    logic [N-1:0]  pa, pb, pc, pd, pf;
    logic          rv0, rv1, busy;
    logic [N-1:0]  rf;
    logic [CW-1:0] cnt0, cnt1;

    pipe1_sched #(.N(N), .LAT(3), .CW(CW)) dut (
        .clk(clk), .reset(reset), .en(en), .v0(v0), .v1(v1),
        .rdy0(rdy0), .rdy1(rdy1),
        .a0(a0), .b0(b0), .c0(c0), .d0(d0),
        .a1(a1), .b1(b1), .c1(c1), .d1(d1),
        .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pf(pf),
        .rv0(rv0), .rv1(rv1), .rf(rf), .busy(busy),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    // Reset-less arithmetic pipeline: three register stages after pa..pd
    logic [N-1:0] s1_ab, s1_cd, s1_d, s2_sum, s2_d;
    always @(posedge clk) begin
        s1_ab  <= pa + pb;
        s1_cd  <= pc - pd;
        s1_d   <= pd;
        s2_sum <= s1_ab + s1_cd;
        s2_d   <= s1_d;
        pf     <= N'(s2_sum * s2_d);
    end

    // Scoreboard and reference state
    typedef struct {
        logic         tag;
        logic [N-1:0] f;
        int           due;
    } ent_t;
    ent_t          sb[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    logic          m_prio;
    logic [CW-1:0] m_cnt0, m_cnt1;

    function automatic logic [N-1:0] calc_f(logic [N-1:0] a, logic [N-1:0] b,
                                            logic [N-1:0] c, logic [N-1:0] d);
        logic [N-1:0] s;
        s = a + b + (c - d);
        return N'(s * d);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks outputs away from the edge, then predicts the next edge
    always @(negedge clk) begin
        logic e_rdy0, e_rdy1;
        ent_t e;
        if (reset) begin
            chk("rst_rv0", {31'd0, rv0}, 32'd0);
            chk("rst_rv1", {31'd0, rv1}, 32'd0);
            chk("rst_rf", {22'd0, rf}, 32'd0);
            chk("rst_pa", {22'd0, pa}, 32'd0);
            chk("rst_cnt0", {24'd0, cnt0}, 32'd0);
            chk("rst_cnt1", {24'd0, cnt1}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            sb.delete();
            m_prio = 1'b0;
            m_cnt0 = 8'd0;
            m_cnt1 = 8'd0;
        end else begin
            chk("busy", {31'd0, busy}, {31'd0, (sb.size() != 0)});
            chk("cnt0", {24'd0, cnt0}, {24'd0, m_cnt0});
            chk("cnt1", {24'd0, cnt1}, {24'd0, m_cnt1});
            if (rv0 && rv1) chk("rv_both", 32'd1, 32'd0);
            if (rv0 || rv1) begin
                if (sb.size() == 0) begin
                    chk("rv_spurious", {31'd0, rv1}, 32'd2);
                end else begin
                    e = sb.pop_front();
                    chk("rv_tag", {31'd0, rv1}, {31'd0, e.tag});
                    chk("rf", {22'd0, rf}, {22'd0, e.f});
                    chk("rv_latency", cyc, e.due);
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                chk("rv_missing", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
            e_rdy0 = en & v0 & (~m_prio | ~v1);
            e_rdy1 = en & v1 & ( m_prio | ~v0);
            chk("rdy0", {31'd0, rdy0}, {31'd0, e_rdy0});
            chk("rdy1", {31'd0, rdy1}, {31'd0, e_rdy1});
            if (e_rdy0) begin
                e.tag = 1'b0; e.f = calc_f(a0, b0, c0, d0); e.due = cyc + 5;
                sb.push_back(e);
                m_cnt0 = m_cnt0 + 8'd1;
                m_prio = 1'b1;
            end else if (e_rdy1) begin
                e.tag = 1'b1; e.f = calc_f(a1, b1, c1, d1); e.due = cyc + 5;
                sb.push_back(e);
                m_cnt1 = m_cnt1 + 8'd1;
                m_prio = 1'b0;
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ops0(int a, int b, int c, int d);
        a0 = N'(a); b0 = N'(b); c0 = N'(c); d0 = N'(d);
    endtask

    task automatic ops1(int a, int b, int c, int d);
        a1 = N'(a); b1 = N'(b); c1 = N'(c); d1 = N'(d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; v0 = 1'b0; v1 = 1'b0;
        ops0(0, 0, 0, 0); ops1(0, 0, 0, 0);
        #2;
        do_reset();

        // T1 single set from r0
        en = 1'b1; ops0(10, 12, 6, 3); v0 = 1'b1;
        step(1); v0 = 1'b0;
        step(8);

        // T2 contention straight after reset: r0 first, r1 next
        do_reset();
        ops0(10, 10, 5, 3); ops1(20, 11, 1, 4);
        v0 = 1'b1; v1 = 1'b1;
        step(1); v0 = 1'b0;
        step(1); v1 = 1'b0;
        step(8);

        // T3 streaming from r1
        v1 = 1'b1; ops1(10, 12, 6, 3);
        step(1); ops1(10, 10, 5, 3);
        step(1); ops1(20, 11, 1, 4);
        step(1); v1 = 1'b0;
        step(8);

        // T4 enable drop with r0 still valid
        v0 = 1'b1; ops0(1, 2, 3, 4);
        step(1); ops0(5, 6, 7, 2);
        step(1); en = 1'b0;
        step(3); v0 = 1'b0; en = 1'b1;
        step(8);

        // T5 reset two edges after an accept: the result is dropped
        v0 = 1'b1; ops0(7, 7, 7, 7);
        step(1); v0 = 1'b0;
        step(1);
        do_reset();
        en = 1'b1;
        step(8);

        // T6 counter wrap: 256 accepts from r0, first one is the 1023+1 case
        ops0(1023, 1, 0, 0); v0 = 1'b1;
        step(1);
        for (int i = 1; i < 256; i++) begin
            ops0($urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 1023), $urandom_range(0, 1023));
            step(1);
        end
        v0 = 1'b0;
        step(8);

        // Random mix of both requesters and enable
        for (int i = 0; i < 200; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 3) != 0);
            ops0($urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 1023), $urandom_range(0, 1023));
            ops1($urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 1023), $urandom_range(0, 1023));
            step(1);
        end
        v0 = 1'b0; v1 = 1'b0;
        step(8);

        @(negedge clk);
        chk("drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
